// File: rtl/hack_pkg.sv
// -----------------------------------------------------------------------------
// hack_pkg
// Shared definitions for the Hack CPU codebase: word and ROM address widths,
// plus the fetch-stage state encoding.
// -----------------------------------------------------------------------------
package hack_pkg;

    localparam int HACK_WORD_W = 16;
    // The instruction ROM holds 2**ROM_ADDR_W words and indexes pc[ROM_ADDR_W-1:0].
    localparam int ROM_ADDR_W  = 11;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

endpackage : hack_pkg

// File: rtl/hack_fetch.sv
// -----------------------------------------------------------------------------
// hack_fetch
// Instruction-fetch stage for the Hack CPU. Presents pc to a combinational
// instruction ROM, captures the returned word into an output register and
// offers it to decode over a valid/ready handshake. Supports sequential
// fetch, taken-jump redirect with squash, and a level halt request.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   pc           out  fetch address to the ROM
//   rom_instr    in   ROM data for pc, same cycle
//   instr        out  registered instruction to decode
//   instr_pc     out  address instr was fetched from
//   instr_valid  out  instr/instr_pc hold a live instruction
//   instr_ready  in   decode accepts instr this cycle
//   jump         in   taken-jump pulse from execute
//   jump_addr    in   jump target
//   halt         in   level request to stop fetching
//   halted       out  fetch frozen and output register empty
// -----------------------------------------------------------------------------
module hack_fetch
    import hack_pkg::*;
#(
    parameter logic [HACK_WORD_W-1:0] RESET_PC = 16'h0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [HACK_WORD_W-1:0] pc,
    input  logic [HACK_WORD_W-1:0] rom_instr,
    output logic [HACK_WORD_W-1:0] instr,
    output logic [HACK_WORD_W-1:0] instr_pc,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    input  logic                   jump,
    input  logic [HACK_WORD_W-1:0] jump_addr,
    input  logic                   halt,
    output logic                   halted
);

    fetch_state_t           r_state;
    fetch_state_t           w_state_next;
    logic [HACK_WORD_W-1:0] r_pc;
    logic [HACK_WORD_W-1:0] r_instr;
    logic [HACK_WORD_W-1:0] r_instr_pc;
    logic                   r_instr_valid;
    logic                   r_halted;

    // Output register is free this edge: either empty or being consumed.
    logic w_slot_free;
    logic w_load;

    assign w_slot_free = !r_instr_valid || instr_ready;
    assign w_load      = (r_state == RUN) && !halt && w_slot_free;

    // A jump edge leaves the state alone, so halt entry/exit waits for a
    // non-jump edge.
    always_comb begin
        // NOTE: default assignment first so every path drives the signal and no latch is inferred.
        w_state_next = r_state;
        if (!jump) begin
            case (r_state)
                RUN:     if (halt && w_slot_free) w_state_next = HALT;
                HALT:    if (!halt)               w_state_next = RUN;
                default: w_state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= RUN;
            r_pc          <= RESET_PC;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state  <= w_state_next;
            r_halted <= (r_state == HALT);
            if (jump) begin
                // Redirect and squash: whatever decode takes this edge is still
                // delivered, but nothing new is captured from the stale pc.
                r_pc          <= jump_addr;
                r_instr_valid <= 1'b0;
            end else if (w_load) begin
                r_instr       <= rom_instr;
                r_instr_pc    <= r_pc;
                r_instr_valid <= 1'b1;
                r_pc          <= r_pc + 16'd1;
            end else if (r_instr_valid && instr_ready) begin
                r_instr_valid <= 1'b0;
            end
        end
    end

    assign pc          = r_pc;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_instr_valid;
    assign halted      = r_halted;

endmodule : hack_fetch

// File: tb/tb_hack_fetch.sv
// -----------------------------------------------------------------------------
// tb_hack_fetch
// Two fetch stages (reset PC 0x0000 and 0xFFFF) share one ROM image and one
// set of control inputs; each is compared every cycle against its own
// transaction-level model of the fetch rules, with directed checks on top.
// -----------------------------------------------------------------------------
module tb_hack_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_ready = 1'b0;
    logic        jump = 1'b0;
    logic [15:0] jump_addr = 16'h0000;
    logic        halt = 1'b0;

    logic [15:0] rom [2048];

    logic [15:0] pc0, instr0, ipc0, rom0;
    logic        valid0, halted0;
    logic [15:0] pc1, instr1, ipc1, rom1;
    logic        valid1, halted1;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    assign rom0 = rom[pc0[10:0]];
    assign rom1 = rom[pc1[10:0]];

    hack_fetch #(.RESET_PC(16'h0000)) dut0 (
        .clk(clk), .rst_n(rst_n), .pc(pc0), .rom_instr(rom0),
        .instr(instr0), .instr_pc(ipc0), .instr_valid(valid0),
        .instr_ready(instr_ready), .jump(jump), .jump_addr(jump_addr),
        .halt(halt), .halted(halted0)
    );

    hack_fetch #(.RESET_PC(16'hFFFF)) dut1 (
        .clk(clk), .rst_n(rst_n), .pc(pc1), .rom_instr(rom1),
        .instr(instr1), .instr_pc(ipc1), .instr_valid(valid1),
        .instr_ready(instr_ready), .jump(jump), .jump_addr(jump_addr),
        .halt(halt), .halted(halted1)
    );

    // ---------------- reference model ----------------
    // Per instance: next address to fetch, the instruction offered to decode
    // (if any), whether fetching is stopped, and the delayed halted flag.
    logic [15:0] m_pc     [2];
    logic [15:0] m_instr  [2];
    logic [15:0] m_ipc    [2];
    bit          m_valid  [2];
    bit          m_frozen [2];
    bit          m_halted [2];

    function automatic logic [15:0] reset_pc(int k);
        return (k == 0) ? 16'h0000 : 16'hFFFF;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k]     = reset_pc(k);
            m_instr[k]  = 16'h0000;
            m_ipc[k]    = 16'h0000;
            m_valid[k]  = 1'b0;
            m_frozen[k] = 1'b0;
            m_halted[k] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            bit was_frozen = m_frozen[k];
            bit consumed   = m_valid[k] && instr_ready;
            bit empty      = !m_valid[k] || consumed;
            if (jump) begin
                m_pc[k]    = jump_addr;
                m_valid[k] = 1'b0;
            end else begin
                if (!was_frozen && !halt && empty) begin
                    m_instr[k] = rom[m_pc[k][10:0]];
                    m_ipc[k]   = m_pc[k];
                    m_valid[k] = 1'b1;
                    m_pc[k]    = m_pc[k] + 16'd1;
                end else if (consumed) begin
                    m_valid[k] = 1'b0;
                end
                if (!was_frozen && halt && empty) m_frozen[k] = 1'b1;
                else if (was_frozen && !halt)     m_frozen[k] = 1'b0;
            end
            m_halted[k] = was_frozen;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_model();
        check("d0.pc",       pc0,              m_pc[0]);
        check("d0.valid",    {15'd0, valid0},  {15'd0, m_valid[0]});
        check("d0.halted",   {15'd0, halted0}, {15'd0, m_halted[0]});
        check("d0.instr",    instr0,           m_instr[0]);
        check("d0.instr_pc", ipc0,             m_ipc[0]);
        check("d1.pc",       pc1,              m_pc[1]);
        check("d1.valid",    {15'd0, valid1},  {15'd0, m_valid[1]});
        check("d1.halted",   {15'd0, halted1}, {15'd0, m_halted[1]});
        check("d1.instr",    instr1,           m_instr[1]);
        check("d1.instr_pc", ipc1,             m_ipc[1]);
    endtask

    // One clock edge: advance the model with the inputs held across the edge,
    // then compare just after the edge.
    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        check_model();
    endtask

    localparam logic [15:0] PROG0 = 16'h0005;
    localparam logic [15:0] PROG1 = 16'hEC10;
    localparam logic [15:0] PROG2 = 16'h0002;
    localparam logic [15:0] PROG3 = 16'hE308;

    logic [15:0] frozen_pc;

    initial begin
        for (int i = 0; i < 2048; i++) rom[i] = 16'($urandom);
        rom[0] = PROG0;
        rom[1] = PROG1;
        rom[2] = PROG2;
        rom[3] = PROG3;
        model_reset();

        // Reset state.
        #12;
        check_model();
        check("rst.valid0", {15'd0, valid0}, 16'd0);
        @(negedge clk);
        rst_n       = 1'b1;
        instr_ready = 1'b1;

        // Streaming: words 0..2 on consecutive edges; 0xFFFF instance wraps.
        step();
        check("seq.instr0", instr0, PROG0);
        check("seq.ipc0",   ipc0,   16'h0000);
        check("wrap.ipc_a", ipc1,   16'hFFFF);
        check("wrap.instr_a", instr1, rom[2047]);
        step();
        check("seq.instr1", instr0, PROG1);
        check("wrap.ipc_b", ipc1,   16'h0000);
        check("wrap.instr_b", instr1, PROG0);
        step();
        check("seq.instr2", instr0, PROG2);
        check("seq.ipc2",   ipc0,   16'h0002);

        // Backpressure: output register and pc hold for three cycles.
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall.instr", instr0, PROG2);
            check("stall.ipc",   ipc0,   16'h0002);
            check("stall.pc",    pc0,    16'h0003);
            check("stall.valid", {15'd0, valid0}, 16'd1);
        end
        instr_ready = 1'b1;
        step();
        check("resume.instr", instr0, PROG3);
        check("resume.ipc",   ipc0,   16'h0003);

        // Jump while instr_pc 5 is valid: one bubble, address 6 skipped.
        step();
        step();
        check("pre_jump.ipc", ipc0, 16'h0005);
        jump      = 1'b1;
        jump_addr = 16'h0010;
        step();
        jump = 1'b0;
        check("jump.squash", {15'd0, valid0}, 16'd0);
        check("jump.pc",     pc0, 16'h0010);
        step();
        check("jump.target", ipc0, 16'h0010);
        check("jump.tvalid", {15'd0, valid0}, 16'd1);

        // Halt while streaming: last word drained, then halted and pc frozen.
        step();
        halt = 1'b1;
        step();
        check("halt.drain", {15'd0, valid0}, 16'd0);
        frozen_pc = pc0;
        step();
        check("halt.halted", {15'd0, halted0}, 16'd1);
        step();
        check("halt.pc_frozen", pc0, frozen_pc);
        halt = 1'b0;
        step();
        step();
        check("halt.resume_ipc", ipc0, frozen_pc);
        check("halt.cleared", {15'd0, halted0}, 16'd0);

        // Asynchronous reset mid-stream at pc 7.
        jump      = 1'b1;
        jump_addr = 16'h0007;
        step();
        check("pre_rst.pc", pc0, 16'h0007);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("arst.pc",    pc0,   16'h0000);
        check("arst.instr", instr0, 16'h0000);
        check("arst.valid", {15'd0, valid0}, 16'd0);
        check_model();
        step();
        @(negedge clk);
        jump  = 1'b0;
        rst_n = 1'b1;
        step();
        check("post_rst.ipc",   ipc0,  16'h0000);
        check("post_rst.instr", instr0, PROG0);

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            instr_ready = ($urandom_range(0, 9) < 7);
            jump        = ($urandom_range(0, 9) == 0);
            jump_addr   = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
            if ($urandom_range(0, 19) == 0) halt = ~halt;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_hack_fetch
